axis_flush_pipeline: RTL
========================

// Module: axis_flush_pipeline
// PURPOSE
// Parametrised AXI-Stream pipeline of PL_DEPTH full-throughput skid stages for
// long-route timing closure in the PCIe SS datapath. It adds three things to a plain
// register chain: a live occupancy count, a synchronous flush that discards every
// held beat, and packet-aware drop of the remainder of an interrupted ingress packet.
// It sits between pcie_ss_axis_if endpoints and uses flat sink/source ports.
// PARAMETERS
// PL_DEPTH        2    number of skid stages, >=1; capacity = 2*PL_DEPTH beats
// TDATA_WIDTH     512  tdata width; tkeep is TDATA_WIDTH/8
// TUSER_WIDTH     10   tuser width
// ENABLE_TLAST    1    1: packet-aware flush/drop; 0: tlast ignored, m_tlast tied 1
// TREADY_RST_VAL  0    s_tready value while rst_n low
// CNT_WIDTH       16   width of drop_cnt (saturating)
// PORTS
// clk          in   1                  clock
// rst_n        in   1                  async active-low reset
// s_tvalid     in   1                  sink valid
// s_tready     out  1                  sink ready
// s_tdata      in   TDATA_WIDTH        sink data
// s_tkeep      in   TDATA_WIDTH/8      sink byte enables
// s_tlast      in   1                  sink end of packet
// s_tuser      in   TUSER_WIDTH        sink sideband
// m_tvalid/m_tready/m_tdata/m_tkeep/m_tlast/m_tuser  out/in/out/out/out/out   source, same widths
// flush        in   1                  synchronous flush request, 1-cycle pulse or level
// occupancy    out  $clog2(2*PL_DEPTH+1)  beats currently held
// drop_cnt     out  CNT_WIDTH          beats discarded since reset, saturating
// trunc_err    out  1                  1-cycle pulse: flush cut an egress packet mid-flight
// BEHAVIOUR
// - Reset: async on rst_n low. m_tvalid=0, occupancy=0, drop_cnt=0, trunc_err=0,
//   s_tready=TREADY_RST_VAL, drop state IDLE. s_tready=1 from the first clk edge after release.
// - Each stage has a main and a skid register, and registered tready. A stage accepts a beat
//   when valid&&ready and presents it on the next edge. Empty-pipe latency is PL_DEPTH cycles.
//   Sustained throughput is 1 beat/clk with no bubbles.
// - AXIS rules: m_tvalid never drops until a handshake occurs, and payload is stable while
//   m_tvalid&&!m_tready. s_tready must not depend combinationally on m_tready.
// - occupancy: +1 on an ingress handshake, -1 on an egress handshake, unchanged when both occur
//   in the same cycle. Its range is 0..2*PL_DEPTH. s_tready=0 only when stage 0 is full.
// - flush=1 in cycle T:
//   - s_tready and m_tvalid are gated to 0 in T, so no handshake occurs on either side.
//   - At edge T+1 all stages are emptied, occupancy=0, and drop_cnt += beats held at T
//     (saturating at all-ones).
//   - trunc_err pulses in T+1 if egress is mid-packet: a beat without tlast was sent and the
//     closing tlast was not.
//   - Level flush holds this state. The pipe resumes normally in the first cycle with flush=0.
// - Ingress drop (ENABLE_TLAST=1): states IDLE, DROP.
//   - IDLE->DROP at the flush edge if ingress is mid-packet (last accepted beat had tlast=0).
//   - In DROP: s_tready=1, and incoming beats are consumed, counted in drop_cnt, and not stored.
//   - DROP->IDLE on the accepted beat with s_tlast=1. That beat is dropped too.
//   - If flush is asserted again while in DROP, the block stays in DROP.
//   - ENABLE_TLAST=0: no DROP state, and mid-packet tracking is disabled (trunc_err stays 0).
// - Reset mid-operation discards all beats without counting them. Packet tracking returns to
//   start-of-packet.
// TESTING
// 1 PL_DEPTH=3, 100 back-to-back beats (data=index), m_tready=1 -> first m_tvalid 3 clk after
//   first accept, then 100 beats in order, no gaps.
// 2 Random m_tready 50%, 1000 beats -> no loss/dup/reorder, m_tvalid and payload stable while
//   stalled, occupancy never exceeds 6.
// 3 PL_DEPTH=2, m_tready=0, push 4 beats (pkt A, no tlast) -> s_tready=0, occupancy=4. Flush 1 clk
//   -> occupancy=0, drop_cnt=4. Next 3 beats (last has tlast) dropped, drop_cnt=7. Next packet
//   B passes intact.
// 4 Egress sent 2 beats of a 5-beat packet, then flush -> trunc_err pulses exactly once at T+1,
//   m_tvalid=0 at T.
// 5 Simultaneous ingress and egress handshakes at occupancy=2 -> stays 2. Then assert rst_n low
//   mid-stream -> m_tvalid=0 and occupancy=0 immediately, s_tready=TREADY_RST_VAL.
// 6 CNT_WIDTH=4, flush-drop 20 beats -> drop_cnt holds at 15.

Source files
------------

// File: rtl/axis_flush_pipeline.sv
// AXI-Stream skid-buffer pipeline with occupancy count, synchronous flush and ingress packet drop.
// Latency: PL_DEPTH cycles through an empty pipe, 1 beat/clk sustained throughput.
// Backpressure: registered tready per stage, so s_tready never depends combinationally on m_tready.
// Ports: clk/rst_n; s_* sink AXIS; m_* source AXIS; flush request;
//        occupancy (beats held), drop_cnt (saturating discard count), trunc_err (egress cut pulse).
module axis_flush_pipeline #(
  parameter int PL_DEPTH       = 2,
  parameter int TDATA_WIDTH    = 512,
  parameter int TUSER_WIDTH    = 10,
  parameter bit ENABLE_TLAST   = 1'b1,
  parameter bit TREADY_RST_VAL = 1'b0,
  parameter int CNT_WIDTH      = 16,
  localparam int KEEP_W        = TDATA_WIDTH / 8,
  localparam int OCC_W         = $clog2(2 * PL_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic [TDATA_WIDTH-1:0] s_tdata,
  input  logic [KEEP_W-1:0]      s_tkeep,
  input  logic                   s_tlast,
  input  logic [TUSER_WIDTH-1:0] s_tuser,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [TDATA_WIDTH-1:0] m_tdata,
  output logic [KEEP_W-1:0]      m_tkeep,
  output logic                   m_tlast,
  output logic [TUSER_WIDTH-1:0] m_tuser,
  input  logic                   flush,
  output logic [OCC_W-1:0]       occupancy,
  output logic [CNT_WIDTH-1:0]   drop_cnt,
  output logic                   trunc_err
);

  localparam int PW    = TUSER_WIDTH + 1 + KEEP_W + TDATA_WIDTH;
  localparam int SUM_W = ((CNT_WIDTH > OCC_W) ? CNT_WIDTH : OCC_W) + 1;

  typedef enum logic {IDLE, DROP} drop_state_t;

  drop_state_t state_q, state_d;
  logic        in_drop;
  logic        rdy_en;    // low until the first edge after reset release
  logic        in_mid;    // last accepted ingress beat had no tlast
  logic        eg_mid;    // last sent egress beat had no tlast
  logic        push, pop, drop_beat;
  logic        tlast_raw;

  // link index i feeds stage i; link PL_DEPTH is the pipe output
  logic [PL_DEPTH:0] link_vld;
  logic [PL_DEPTH:0] link_rdy;
  logic [PW-1:0]     link_dat [PL_DEPTH+1];

  assign s_tready  = rdy_en ? (!flush && (in_drop || link_rdy[0])) : TREADY_RST_VAL;
  assign push      = s_tvalid && s_tready && !in_drop;
  assign drop_beat = s_tvalid && s_tready && in_drop;
  assign m_tvalid  = link_vld[PL_DEPTH] && !flush;
  assign pop       = m_tvalid && m_tready;

  assign link_vld[0]        = push;
  assign link_dat[0]        = {s_tuser, s_tlast, s_tkeep, s_tdata};
  assign link_rdy[PL_DEPTH] = m_tready && !flush;

  assign {m_tuser, tlast_raw, m_tkeep, m_tdata} = link_dat[PL_DEPTH];
  assign m_tlast = ENABLE_TLAST ? tlast_raw : 1'b1;

  for (genvar i = 0; i < PL_DEPTH; i++) begin : g_stage
    logic          main_vld, skid_vld;
    logic [PW-1:0] main_dat, skid_dat;
    logic          in_acc, out_rdy;

    assign out_rdy       = link_rdy[i+1];
    assign in_acc        = link_vld[i] && link_rdy[i];
    assign link_rdy[i]   = !skid_vld;
    assign link_vld[i+1] = main_vld;
    assign link_dat[i+1] = main_dat;

    // The skid register only fills when the main register is held by downstream,
    // which is what lets ready be a plain flop.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        main_vld <= 1'b0;
        skid_vld <= 1'b0;
      end else if (flush) begin
        main_vld <= 1'b0;
        skid_vld <= 1'b0;
      end else if (skid_vld) begin
        if (out_rdy) skid_vld <= 1'b0;
      end else if (in_acc) begin
        if (main_vld && !out_rdy) skid_vld <= 1'b1;
        else                      main_vld <= 1'b1;
      end else if (out_rdy) begin
        main_vld <= 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (skid_vld) begin
        if (out_rdy) main_dat <= skid_dat;
      end else if (in_acc) begin
        if (main_vld && !out_rdy) skid_dat <= link_dat[i];
        else                      main_dat <= link_dat[i];
      end
    end
  end

  // Ingress drop FSM
  always_comb begin
    state_d = state_q;
    in_drop = (state_q == DROP);
    if (ENABLE_TLAST) begin
      case (state_q)
        IDLE:    if (flush && in_mid) state_d = DROP;
        DROP:    if (drop_beat && s_tlast) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Flush retires every held beat at once; otherwise only dropped ingress beats count.
  logic [OCC_W-1:0] drop_add;
  logic [SUM_W-1:0] drop_sum;
  logic [CNT_WIDTH-1:0] drop_cnt_d;
  always_comb begin
    drop_add   = flush ? occupancy : OCC_W'(drop_beat);
    drop_sum   = SUM_W'(drop_cnt) + SUM_W'(drop_add);
    drop_cnt_d = (drop_sum > SUM_W'({CNT_WIDTH{1'b1}})) ? {CNT_WIDTH{1'b1}}
                                                         : drop_sum[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rdy_en    <= 1'b0;
      in_mid    <= 1'b0;
      eg_mid    <= 1'b0;
      occupancy <= '0;
      drop_cnt  <= '0;
      trunc_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      rdy_en    <= 1'b1;
      drop_cnt  <= drop_cnt_d;
      trunc_err <= flush && eg_mid;
      if (flush) begin
        occupancy <= '0;
        in_mid    <= 1'b0;
        eg_mid    <= 1'b0;
      end else begin
        occupancy <= occupancy + OCC_W'(push) - OCC_W'(pop);
        if (push) in_mid <= ENABLE_TLAST && !s_tlast;
        if (pop)  eg_mid <= ENABLE_TLAST && !tlast_raw;
      end
    end
  end

endmodule
